// File: rtl/odo_sbox_pkg.sv
// Shared defaults and state encoding for the S-box lookup bank.
package odo_sbox_pkg;

    localparam int W_DEF     = 6;
    localparam int LANES_DEF = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } state_e;

endpackage

// File: rtl/odo_sbox_ram.sv
// S-box table: one write port, LANES registered read ports.
// Entries are stored XORed with their own address, so storage that powers up
// all-zero reads back as the identity table. Storage has no reset and keeps
// its contents across rst_n; only the read registers are reset.
module odo_sbox_ram
    import odo_sbox_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [W-1:0]              wr_addr,
    input  logic [W-1:0]              wr_data,
    input  logic                      rd_en,
    input  logic [LANES-1:0][W-1:0]   rd_addr,
    output logic [LANES-1:0][W-1:0]   rd_data
);

    localparam int DEPTH = 1 << W;

    logic [W-1:0] mem_q [DEPTH];

    // Table write, address-scrambled encoding
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data ^ wr_addr;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_rd
        logic [W-1:0] lane_q, lane_d;

        // Per-lane read: decode stored word, hold when stalled
        always_comb begin
            lane_d = lane_q;
            if (rd_en) lane_d = mem_q[rd_addr[k]] ^ rd_addr[k];
        end

        // Per-lane read register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) lane_q <= '0;
            else        lane_q <= lane_d;
        end

        assign rd_data[k] = lane_q;
    end

endmodule

// File: rtl/odo_sbox_bank.sv
// Multi-lane S-box lookup bank with in-band table reprogramming.
// Two stages: input register, then table read register (inside the RAM).
// Optional inverse table enabled by defining ODO_SBOX_INV_EN.
module odo_sbox_bank
    import odo_sbox_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_data,
`ifdef ODO_SBOX_INV_EN
    input  logic                 in_inv,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   out_data,
    input  logic                 load_start,
    input  logic                 load_valid,
    input  logic [W-1:0]         load_data,
    output logic                 load_done
);

    localparam int STAGES = 2;

    state_e                    state_q, state_d;
    logic [W-1:0]              cnt_q, cnt_d;
    logic [STAGES:1]           vld_pipe_q, vld_pipe_d;
    logic [LANES-1:0][W-1:0]   s1_sym_q, s1_sym_d;
    logic                      load_done_q, load_done_d;
    logic                      alive_q, alive_d;

    logic                      adv, in_fire, wr_en, last_wr;
    logic [LANES-1:0][W-1:0]   fwd_rd;

    // alive_q keeps in_ready low while reset is asserted
    assign adv      = !vld_pipe_q[STAGES] || out_ready;
    assign in_ready = adv && (state_q == RUN) && alive_q;
    assign in_fire  = in_valid && in_ready;
    assign wr_en    = (state_q == LOAD) && load_valid;
    assign last_wr  = wr_en && (cnt_q == {W{1'b1}});

    assign out_valid = vld_pipe_q[STAGES];
    assign load_done = load_done_q;

    // Pipeline valids and input stage; everything holds while stalled
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        s1_sym_d   = s1_sym_q;
        if (adv) begin
            vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_fire};
            if (in_fire) s1_sym_d = in_data;
        end
    end

    // Mode FSM: drain in-flight lookups, then stream in a full table
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_done_d = 1'b0;
        alive_d     = 1'b1;
        case (state_q)
            RUN:   if (load_start) state_d = DRAIN;
            DRAIN: if (vld_pipe_q == '0) state_d = LOAD;
            LOAD: begin
                if (wr_en) cnt_d = cnt_q + 1'b1;
                if (last_wr) begin
                    state_d     = RUN;
                    load_done_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Control and input-stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            vld_pipe_q  <= '0;
            s1_sym_q    <= '0;
            load_done_q <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vld_pipe_q  <= vld_pipe_d;
            s1_sym_q    <= s1_sym_d;
            load_done_q <= load_done_d;
            alive_q     <= alive_d;
        end
    end

    odo_sbox_ram #(.W(W), .LANES(LANES)) u_fwd (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (cnt_q),
        .wr_data (load_data),
        .rd_en   (adv),
        .rd_addr (s1_sym_q),
        .rd_data (fwd_rd)
    );

`ifdef ODO_SBOX_INV_EN
    logic                      s1_inv_q, s1_inv_d;
    logic                      s2_inv_q, s2_inv_d;
    logic [LANES-1:0][W-1:0]   inv_rd;

    // Inverse-select flag travels alongside the lookup
    always_comb begin
        s1_inv_d = s1_inv_q;
        s2_inv_d = s2_inv_q;
        if (adv) begin
            s2_inv_d = s1_inv_q;
            if (in_fire) s1_inv_d = in_inv;
        end
    end

    // Inverse-select flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_inv_q <= 1'b0;
            s2_inv_q <= 1'b0;
        end else begin
            s1_inv_q <= s1_inv_d;
            s2_inv_q <= s2_inv_d;
        end
    end

    // Inverse table: written at the loaded value, storing its index
    odo_sbox_ram #(.W(W), .LANES(LANES)) u_inv (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (load_data),
        .wr_data (cnt_q),
        .rd_en   (adv),
        .rd_addr (s1_sym_q),
        .rd_data (inv_rd)
    );

    assign out_data = s2_inv_q ? inv_rd : fwd_rd;
`else
    assign out_data = fwd_rd;
`endif

endmodule

// File: doc/odo_sbox_bank.md
ODO_SBOX_BANK -- requirements
Module: odo_sbox_bank

Interface
REQ-001 SHALL have parameter W, default 6, meaning S-box symbol width; table depth is 2**W.
REQ-002 SHALL have parameter LANES, default 4, meaning number of parallel lookups per transaction.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  lookup request valid.
REQ-006 SHALL have port in_ready  output  1  lookup request accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data  input  LANES*W  lane k at bits [k*W +: W].
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts result.
REQ-010 SHALL have port out_data  output  LANES*W  lane k = table[in lane k].
REQ-011 SHALL have port load_start  input  1  one-cycle request to begin reprogramming the table.
REQ-012 SHALL have port load_valid  input  1  load word valid.
REQ-013 SHALL have port load_data  input  W  table entry for the current load address.
REQ-014 SHALL have port load_done  output  1  one-cycle pulse after the last entry is written.

Function
REQ-015 SHALL hold one table of 2**W entries of W bits, read by all LANES lanes in the same cycle.
REQ-016 SHALL implement a 2-stage pipeline (input register, table read register); out_valid SHALL rise 2 cycles after acceptance when out_ready is held high.
REQ-017 SHALL advance the pipeline only when adv = !out_valid || out_ready; when adv is low all stage registers and out_data SHALL hold.
REQ-018 SHALL drive in_ready = adv && state==RUN; full throughput of one transaction per cycle when out_ready stays high.
REQ-019 SHALL use states RUN, DRAIN, LOAD; RUN->DRAIN on load_start; DRAIN->LOAD when both stages are empty; LOAD->RUN after entry 2**W-1 is written.
REQ-020 SHALL in LOAD write load_data to address cnt on each load_valid cycle, cnt starting at 0 and incrementing by 1; cnt SHALL wrap to 0 on leaving LOAD.
REQ-021 SHALL pulse load_done in the cycle the state returns to RUN; in_ready SHALL go high no earlier than that cycle.
REQ-022 SHALL ignore load_valid outside LOAD and load_start outside RUN.
REQ-023 SHALL, when load_start and an accepted in_valid coincide in RUN, accept the lookup and complete it with the old table.
REQ-024 SHALL read a newly written entry correctly in the first lookup after load_done.

Reset
REQ-025 SHALL on rst_n low: out_valid=0, out_data=0, load_done=0, in_ready=0 during reset, state=RUN, cnt=0, stage valids=0.
REQ-026 SHALL NOT reset table contents; they SHALL power up to identity (entry i = i) and be retained across reset.
REQ-027 SHALL abort a load on reset; partially written entries remain, no load_done pulse.

Configuration
REQ-028 SHALL, with ODO_SBOX_INV_EN defined, add input in_inv (1 bit, sampled with in_data) and an inverse table written inv[load_data]=cnt during LOAD; in_inv=1 lookups SHALL use the inverse table.
REQ-029 SHALL, without ODO_SBOX_INV_EN, have no in_inv port and no inverse table storage.

Structure
REQ-030 SHALL place W default, LANES default, and the state enum typedef in shared package odo_sbox_pkg.
REQ-031 SHALL use one sub-module odo_sbox_ram (1 write port, LANES registered read ports), instantiated once per table.

Verification
REQ-032 SHALL verify after reset with identity table: in_data lanes {0x3f,0x00,0x15,0x2a} -> out_data {0x3f,0x00,0x15,0x2a} 2 cycles later.
REQ-033 SHALL verify load of table[i]=(i+1) mod 64, then lookup {0x00,0x3f,0x10,0x20} -> {0x01,0x00,0x11,0x21}; load_done exactly one pulse after 64th load_valid.
REQ-034 SHALL verify out_ready held low 5 cycles with 3 requests offered -> out_data stable, in_ready low, no request lost or duplicated after release.
REQ-035 SHALL verify load_start with two transactions in flight -> both complete with old table, DRAIN then LOAD, in_ready low until load_done.
REQ-036 SHALL verify rst_n low mid-LOAD after 10 entries -> state RUN, no load_done, entries 0..9 new, 10..63 old.
REQ-037 SHALL verify with ODO_SBOX_INV_EN after the REQ-033 load: in_inv=1, lanes {0x01,0x00,0x11,0x21} -> {0x00,0x3f,0x10,0x20}.
